// File: rtl/ex_mem_flag_stage_pkg.sv
// ex_mem_flag_stage_pkg: flag bit positions, branch condition codes and standard flag-write masks shared by EX-stage blocks
package ex_mem_flag_stage_pkg;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  typedef enum logic [2:0] {
    CCC_NE     = 3'b000,
    CCC_EQ     = 3'b001,
    CCC_GT     = 3'b010,
    CCC_LT     = 3'b011,
    CCC_GE     = 3'b100,
    CCC_LE     = 3'b101,
    CCC_OV     = 3'b110,
    CCC_UNCOND = 3'b111
  } ccc_e;
  localparam logic [2:0] FWE_ALL  = 3'b111;
  localparam logic [2:0] FWE_Z    = 3'b100;
  localparam logic [2:0] FWE_NONE = 3'b000;
endpackage

// File: rtl/ex_mem_flag_stage_flag_reg.sv
// flag_reg: 3-bit flag register, bits written only where en and we_mask are both set; sync active-high rst
module flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] we_mask,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [2:0] q_q;
  logic [2:0] q_d;
  always_comb q_d = en ? (we_mask & d) | (~we_mask & q_q) : q_q;
  always_ff @(posedge clk) q_q <= rst ? 3'b000 : q_d;
  assign q = q_q;
endmodule

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX/MEM pipeline register (rst>flush>stall>capture), masked FLAG register, branch evaluation, flag hazard
module ex_mem_flag_stage
  import ex_mem_flag_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_result,
  input  logic [2:0]    ex_flag,
  input  logic [2:0]    ex_flag_we,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_we,
  input  logic          ex_mem_re,
  input  logic          ex_mem_we,
  input  logic [DW-1:0] ex_store_data,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    br_ccc,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_we,
  output logic          mem_mem_re,
  output logic          mem_mem_we,
  output logic [DW-1:0] mem_store_data,
  output logic [2:0]    flag_q,
  output logic          br_taken,
  output logic          flag_hazard
);
  logic [3:0]    ctl_q, ctl_d;
  logic [DW-1:0] result_q, result_d, sd_q, sd_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          hold;
  logic          z, v, n;
  logic [7:0]    cond;
  assign hold = flush | stall;
  always_comb begin
    ctl_d    = flush ? 4'b0000 : stall ? ctl_q : {4{ex_valid}} & {1'b1, ex_reg_we, ex_mem_re, ex_mem_we};
    result_d = hold ? result_q : ex_result;
    sd_d     = hold ? sd_q : ex_store_data;
    rd_d     = hold ? rd_q : ex_rd;
  end
  always_ff @(posedge clk) begin
    ctl_q    <= rst ? '0 : ctl_d;
    result_q <= rst ? '0 : result_d;
    sd_q     <= rst ? '0 : sd_d;
    rd_q     <= rst ? '0 : rd_d;
  end
  assign {mem_valid, mem_reg_we, mem_mem_re, mem_mem_we} = ctl_q;
  assign mem_result     = result_q;
  assign mem_store_data = sd_q;
  assign mem_rd         = rd_q;
  flag_reg u_flag_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (ex_valid & ~hold),
    .we_mask (ex_flag_we),
    .d       (ex_flag),
    .q       (flag_q)
  );
  assign z = flag_q[FLAG_Z];
  assign v = flag_q[FLAG_V];
  assign n = flag_q[FLAG_N];
  always_comb begin
    cond            = '0;
    cond[CCC_NE]    = ~z;
    cond[CCC_EQ]    = z;
    cond[CCC_GT]    = ~z & ~n;
    cond[CCC_LT]    = n;
    cond[CCC_GE]    = z | (~z & ~n);
    cond[CCC_LE]    = n | z;
    cond[CCC_OV]    = v;
    cond[CCC_UNCOND] = 1'b1;
  end
  assign br_taken    = cond[br_ccc];
  assign flag_hazard = ex_valid & (|ex_flag_we);
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: directed stimulus with a behavioural pipeline/flag model checked every cycle plus literal expectations
module tb_ex_mem_flag_stage;
  localparam int DW = 16;
  localparam int RW = 4;
  logic clk = 0;
  logic rst, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, stall, flush;
  logic [DW-1:0] ex_result, ex_store_data;
  logic [2:0] ex_flag, ex_flag_we, br_ccc;
  logic [RW-1:0] ex_rd;
  logic mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, br_taken, flag_hazard;
  logic [DW-1:0] mem_result, mem_store_data;
  logic [RW-1:0] mem_rd;
  logic [2:0] flag_q;
  int n_cmp = 0;
  int n_bad = 0;
  ex_mem_flag_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result), .ex_flag(ex_flag),
    .ex_flag_we(ex_flag_we), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
    .ex_mem_we(ex_mem_we), .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
    .br_ccc(br_ccc), .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_reg_we(mem_reg_we), .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we),
    .mem_store_data(mem_store_data), .flag_q(flag_q), .br_taken(br_taken), .flag_hazard(flag_hazard)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic br_rule(input logic [2:0] f, input logic [2:0] c);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  logic m_ok = 0, d_ok = 0;
  logic m_valid, m_reg_we, m_re, m_we;
  logic [DW-1:0] m_result, m_sd;
  logic [RW-1:0] m_rd;
  logic [2:0] m_flag;
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; d_ok = 1;
      {m_valid, m_reg_we, m_re, m_we} = 4'b0;
      m_result = 0; m_sd = 0; m_rd = 0; m_flag = 3'b000;
    end else if (flush) begin
      {m_valid, m_reg_we, m_re, m_we} = 4'b0;
      d_ok = 0;
    end else if (!stall) begin
      m_valid = ex_valid;
      m_reg_we = ex_valid && ex_reg_we;
      m_re = ex_valid && ex_mem_re;
      m_we = ex_valid && ex_mem_we;
      m_result = ex_result; m_sd = ex_store_data; m_rd = ex_rd;
      d_ok = 1;
      if (ex_valid)
        for (int i = 0; i < 3; i++)
          if (ex_flag_we[i]) m_flag[i] = ex_flag[i];
    end
  end
  always @(negedge clk) begin
    if (m_ok) begin
      chk("valid", 32'(mem_valid), 32'(m_valid));
      chk("reg_we", 32'(mem_reg_we), 32'(m_reg_we));
      chk("mem_re", 32'(mem_mem_re), 32'(m_re));
      chk("mem_we", 32'(mem_mem_we), 32'(m_we));
      chk("flag", 32'(flag_q), 32'(m_flag));
      chk("br_taken", 32'(br_taken), 32'(br_rule(m_flag, br_ccc)));
      chk("hazard", 32'(flag_hazard), 32'(ex_valid && ex_flag_we != 3'b000));
      if (d_ok) begin
        chk("result", 32'(mem_result), 32'(m_result));
        chk("store_data", 32'(mem_store_data), 32'(m_sd));
        chk("rd", 32'(mem_rd), 32'(m_rd));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic [DW-1:0] r, input logic [2:0] f, input logic [2:0] we,
                    input logic [RW-1:0] rd, input logic rwe, input logic re, input logic mwe);
    ex_valid = v; ex_result = r; ex_flag = f; ex_flag_we = we; ex_rd = rd;
    ex_reg_we = rwe; ex_mem_re = re; ex_mem_we = mwe; ex_store_data = r ^ 16'h00FF;
  endtask
  logic [7:0] exp_a = 8'b1011_0010;
  logic [7:0] exp_b = 8'b1010_1001;
  initial begin
    rst = 1; stall = 0; flush = 0; br_ccc = 0;
    ex(1, 16'h1234, 3'b111, 3'b111, 4'd3, 1, 0, 0);
    step(); step();
    chk("rst valid", 32'(mem_valid), 0);
    chk("rst reg_we", 32'(mem_reg_we), 0);
    chk("rst flag", 32'(flag_q), 0);
    chk("rst result", 32'(mem_result), 0);
    rst = 0;
    ex(1, 16'h1234, 3'b011, 3'b111, 4'd3, 1, 0, 0);
    #1 chk("haz add", 32'(flag_hazard), 1);
    step();
    chk("add flag", 32'(flag_q), 32'h3);
    chk("add result", 32'(mem_result), 32'h1234);
    chk("add valid", 32'(mem_valid), 1);
    stall = 1;
    ex(1, 16'hBEEF, 3'b000, 3'b111, 4'd5, 1, 0, 0);
    step();
    chk("stall result", 32'(mem_result), 32'h1234);
    chk("stall flag", 32'(flag_q), 32'h3);
    chk("stall rd", 32'(mem_rd), 3);
    flush = 1;
    step();
    chk("flush valid", 32'(mem_valid), 0);
    chk("flush reg_we", 32'(mem_reg_we), 0);
    chk("flush flag", 32'(flag_q), 32'h3);
    stall = 0; flush = 0;
    ex(1, 16'h0040, 3'b100, 3'b100, 4'd6, 1, 0, 0);
    step();
    chk("sll flag", 32'(flag_q), 32'h7);
    chk("sll result", 32'(mem_result), 32'h0040);
    ex(0, 16'h5555, 3'b000, 3'b111, 4'd7, 1, 0, 1);
    #1 chk("bubble haz", 32'(flag_hazard), 0);
    step();
    chk("bubble reg_we", 32'(mem_reg_we), 0);
    chk("bubble mem_we", 32'(mem_mem_we), 0);
    chk("bubble flag", 32'(flag_q), 32'h7);
    ex(1, 16'h0000, 3'b100, 3'b111, 4'd1, 1, 0, 0);
    step();
    ex(0, 16'h0000, 3'b000, 3'b000, 4'd0, 0, 0, 0);
    chk("z flag", 32'(flag_q), 32'h4);
    for (int c = 0; c < 8; c++) begin
      br_ccc = 3'(c);
      #1 chk($sformatf("br z ccc%0d", c), 32'(br_taken), 32'(exp_a[c]));
    end
    ex(1, 16'h8000, 3'b001, 3'b111, 4'd2, 1, 0, 0);
    step();
    ex(0, 16'h0000, 3'b000, 3'b000, 4'd0, 0, 0, 0);
    chk("n flag", 32'(flag_q), 32'h1);
    for (int c = 0; c < 8; c++) begin
      br_ccc = 3'(c);
      #1 chk($sformatf("br n ccc%0d", c), 32'(br_taken), 32'(exp_b[c]));
    end
    ex(1, 16'hA5A5, 3'b110, 3'b100, 4'd9, 0, 1, 0);
    #1 chk("haz xor", 32'(flag_hazard), 1);
    step();
    ex(1, 16'h0101, 3'b000, 3'b000, 4'd4, 0, 0, 1);
    #1 chk("haz next", 32'(flag_hazard), 0);
    chk("xor flag", 32'(flag_q), 32'h5);
    chk("load re", 32'(mem_mem_re), 1);
    step();
    chk("store we", 32'(mem_mem_we), 1);
    chk("store data", 32'(mem_store_data), 32'h01FE);
    ex(1, 16'h7777, 3'b010, 3'b111, 4'd8, 1, 0, 0);
    rst = 1; stall = 1; flush = 1;
    step();
    chk("mid rst flag", 32'(flag_q), 0);
    chk("mid rst valid", 32'(mem_valid), 0);
    rst = 0; stall = 0; flush = 0;
    step();
    chk("post rst flag", 32'(flag_q), 32'h2);
    chk("post rst valid", 32'(mem_valid), 1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
- Sits directly downstream of the execute-stage ALU/shifter; consumes its 16-bit result and its Z/V/N flag vector.
- Registers the result and control bits into the EX/MEM pipeline register.
- Owns the architectural FLAG register, updated under a per-bit write mask.
- Evaluates the 3-bit branch condition code against FLAG and reports the flag hazard caused by a flag-writer still in EX.

Parameters:
- DW, 16, datapath width of result and store data
- RW, 4, register-specifier width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX slot holds a real instruction
- ex_result  in  DW  ALU/shifter output
- ex_flag  in  3  flag vector from ALU/shifter, indexed by FLAG_Z/FLAG_V/FLAG_N
- ex_flag_we  in  3  per-bit FLAG write mask: ADD/SUB 3'b111; XOR/SLL/SRA/ROR Z only; others 0
- ex_rd  in  RW  destination register
- ex_reg_we  in  1  register-file write enable
- ex_mem_re  in  1  load
- ex_mem_we  in  1  store
- ex_store_data  in  DW  store data
- stall  in  1  hold EX/MEM register and FLAG
- flush  in  1  squash instruction entering MEM
- br_ccc  in  3  condition code of branch in decode
- mem_valid  out  1  registered ex_valid
- mem_result  out  DW  registered result
- mem_rd  out  RW  registered destination
- mem_reg_we, mem_mem_re, mem_mem_we  out  1 each  registered controls
- mem_store_data  out  DW  registered store data
- flag_q  out  3  architectural FLAG register
- br_taken  out  1  combinational branch decision from flag_q and br_ccc
- flag_hazard  out  1  ex_valid & (|ex_flag_we)

Behaviour:
- Reset (rst=1 at edge):
  - mem_valid, mem_reg_we, mem_mem_re, mem_mem_we = 0.
  - mem_result, mem_store_data, mem_rd = 0.
  - flag_q = 3'b000.
  - Reset overrides stall and flush.
  - Reset mid-operation discards the captured instruction; the flag update from the EX-slot instruction in that cycle is lost.
- Latency: one cycle EX -> MEM for all registered outputs. flag_q reflects an instruction one cycle after it leaves EX.
- Priority each edge: rst > flush > stall > capture.
  - flush=1: mem_valid and all mem_* enables <= 0 regardless of stall. Data fields may hold. FLAG is not written.
  - stall=1 (flush=0): every EX/MEM field and flag_q hold.
  - else: capture all ex_* fields. mem_* enables are ANDed with ex_valid, so a bubble never carries write enables.
- FLAG update:
  - Condition: ex_valid & !stall & !flush & !rst.
  - Each bit i updates when ex_flag_we[i]=1: flag_q[i] <= ex_flag[i]. Bits with mask 0 hold.
- br_taken, from flag_q only (no bypass), by br_ccc:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always 1
- Hazard handling: flag_hazard is purely combinational. The hazard unit stalls decode while it is 1. This block does not self-stall.
- No X on any output after reset; ex_flag_we bits are don't-care when ex_valid=0.

Decomposition:
- Shared header/package holds:
  - FLAG_Z=2, FLAG_V=1, FLAG_N=0
  - CCC_NE..CCC_UNCOND encodings 3'b000..3'b111
  - the standard flag-write masks: FWE_ALL=3'b111, FWE_Z=3'b100, FWE_NONE=3'b000
- The shifter and ALU reuse the same header.
- One sub-module: flag_reg. It is the 3-bit masked register (clk, rst, en, we_mask, d, q), instantiated once. Branch decode stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_valid=1, ex_reg_we=1 -> mem_valid=0, mem_reg_we=0, flag_q=000. The first capture occurs on the edge after rst falls.
- Masked update: ADD with ex_flag=3'b011, ex_flag_we=111 -> flag_q=011. Next, SLL with ex_flag=3'b100, we=100 -> flag_q=111 (V, N held).
- Stall/flush: ex_result=16'hBEEF, stall=1 -> mem_result keeps the prior 16'h1234 and flag_q holds. Then flush=1 with stall=1 -> mem_valid=0, mem_reg_we=0, flag_q unchanged.
- Bubble: ex_valid=0, ex_reg_we=1, ex_mem_we=1, ex_flag_we=111 -> mem_reg_we=0, mem_mem_we=0, flag_q unchanged, flag_hazard=0.
- Branch sweep: with flag_q=100, ccc 000..111 -> br_taken=0,1,0,0,1,1,0,1. With flag_q=001 -> 1,0,0,1,0,1,0,1.
- Hazard: ex_valid=1, ex_flag_we=100 -> flag_hazard=1 in the same cycle. After capture, flag_q reflects the update and flag_hazard follows the next EX instruction.
